// File: rtl/stepper_phase_drv_if.sv
// Drive interface from the tracking regulator to the stepper phase driver.
//   drv_SM   : driver enable (0 de-energizes the coils)
//   drv_step : step request, a rising edge asks for one step
//   drv_dir  : direction, 1 = forward (+1), 0 = reverse (-1)
// master = regulator side, slave = phase driver side.
interface stepper_phase_drv_if;
  logic drv_SM;
  logic drv_step;
  logic drv_dir;

  modport master (output drv_SM, output drv_step, output drv_dir);
  modport slave  (input  drv_SM, input  drv_step, input  drv_dir);
endinterface

// File: rtl/stepper_phase_drv.sv
// Stepper phase driver: turns accepted step requests into a 4-coil phase pattern
// and keeps a signed position count. It enforces a minimum interval between
// accepted steps, and it flags steps that arrive too early.
//
// Optional feature: define STEPPER_HALF_STEP_EN for 8-entry half-step drive.
// With the macro undefined, the block uses the 4-entry two-phase-on full-step table.
//
// Ports:
//   clk       : system clock (50 MHz)
//   rst       : asynchronous reset, active-low
//   drv       : drive interface (drv_SM, drv_step, drv_dir), slave side
//   pos_clr   : synchronous clear of position and step_err
//   coil      : coil drive pattern {A, B, C, D}
//   position  : signed step count, two's complement, wraps
//   step_done : one-cycle pulse per accepted step
//   step_err  : sticky flag, set when a step is rejected by the interval check
//   busy      : high while the interval counter is nonzero
module stepper_phase_drv #(
  parameter int unsigned POS_W        = 16,
  parameter int unsigned MIN_INTERVAL = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  stepper_phase_drv_if.slave       drv,
  input  logic                     pos_clr,
  output logic [3:0]               coil,
  output logic [POS_W-1:0]         position,
  output logic                     step_done,
  output logic                     step_err,
  output logic                     busy
);

`ifdef STEPPER_HALF_STEP_EN
  localparam int unsigned PhW = 3;
`else
  localparam int unsigned PhW = 2;
`endif
  localparam int unsigned CntW = (MIN_INTERVAL > 2) ? $clog2(MIN_INTERVAL) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MIN_INTERVAL - 1);

  typedef enum logic [1:0] {StIdle, StHold, StWait} state_e;

  state_e              state_q, state_d;
  logic                step_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PhW-1:0]      phase_q, phase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [3:0]          coil_q, coil_d;
  logic                done_q, err_q, err_d, busy_q;
  logic                rise, accept, reject;

  function automatic logic [3:0] coil_lut(input logic [PhW-1:0] ph);
    logic [3:0] c;
    c = 4'b0000;
`ifdef STEPPER_HALF_STEP_EN
    case (ph)
      3'd0:    c = 4'b1000;
      3'd1:    c = 4'b1100;
      3'd2:    c = 4'b0100;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0010;
      3'd5:    c = 4'b0011;
      3'd6:    c = 4'b0001;
      default: c = 4'b1001;
    endcase
`else
    case (ph)
      2'd0:    c = 4'b1100;
      2'd1:    c = 4'b0110;
      2'd2:    c = 4'b0011;
      default: c = 4'b1001;
    endcase
`endif
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      step_q  <= 1'b0;
      cnt_q   <= '0;
      phase_q <= '0;
      pos_q   <= '0;
      coil_q  <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= drv.drv_step;  // tracked even while disabled
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      coil_q  <= coil_d;
      done_q  <= accept;
      err_q   <= err_d;
      busy_q  <= (state_d == StWait);
    end
  end

  always_comb begin
    rise   = drv.drv_step & ~step_q;
    // Acceptance ignores the state so that enable and step may rise together.
    accept = drv.drv_SM & rise & (cnt_q == '0);
    reject = drv.drv_SM & rise & (cnt_q != '0);

    phase_d = phase_q;
    if (accept) begin
      phase_d = drv.drv_dir ? phase_q + PhW'(1) : phase_q - PhW'(1);
    end

    cnt_d = cnt_q;
    if (!drv.drv_SM) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = CntLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end

    pos_d = pos_q;
    if (pos_clr) begin
      pos_d = '0;
    end else if (accept) begin
      pos_d = drv.drv_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end

    err_d = err_q;
    if (pos_clr) begin
      err_d = 1'b0;
    end else if (reject) begin
      err_d = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      StIdle:  if (drv.drv_SM) state_d = accept ? StWait : StHold;
      StHold:  if (accept) state_d = StWait;
      StWait:  if (cnt_d == '0) state_d = StHold;
      default: state_d = StIdle;
    endcase
    if (!drv.drv_SM) state_d = StIdle;

    coil_d = (state_d == StIdle) ? 4'b0000 : coil_lut(phase_d);
  end

  assign coil      = coil_q;
  assign position  = pos_q;
  assign step_done = done_q;
  assign step_err  = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_stepper_phase_drv.sv
module tb_stepper_phase_drv;
  localparam int unsigned MinInt = 4;
  localparam int unsigned PosW   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            pos_clr;
  logic [3:0]      coil;
  logic [PosW-1:0] position;
  logic            step_done, step_err, busy;

  stepper_phase_drv_if drv ();

  stepper_phase_drv #(.POS_W(PosW), .MIN_INTERVAL(MinInt)) dut (
    .clk       (clk),
    .rst       (rst),
    .drv       (drv),
    .pos_clr   (pos_clr),
    .coil      (coil),
    .position  (position),
    .step_done (step_done),
    .step_err  (step_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [3:0]      coil;
    logic [PosW-1:0] pos;
  } exp_t;
  exp_t exp_q[$];

  logic [3:0]      tbl [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
  logic [1:0]      m_phase;
  logic [PosW-1:0] m_pos;
  int              m_cnt;
  logic            m_step, m_err;

  // Advance the reference model by one edge, then compare after the edge.
  task automatic tick();
    logic rise, acc, rej;
    logic [3:0] exp_coil;
    exp_t e;
    rise = drv.drv_step & ~m_step;
    acc  = drv.drv_SM & rise & (m_cnt == 0);
    rej  = drv.drv_SM & rise & (m_cnt != 0);
    if (acc) begin
      m_phase = drv.drv_dir ? m_phase + 2'd1 : m_phase - 2'd1;
      m_cnt   = MinInt - 1;
      if (pos_clr) m_pos = '0;
      else m_pos = drv.drv_dir ? m_pos + 16'd1 : m_pos - 16'd1;
      e.coil = tbl[m_phase];
      e.pos  = m_pos;
      exp_q.push_back(e);
    end else begin
      if (m_cnt != 0) m_cnt--;
      if (pos_clr) m_pos = '0;
    end
    if (!drv.drv_SM) m_cnt = 0;
    if (pos_clr) m_err = 1'b0;
    else if (rej) m_err = 1'b1;
    m_step   = drv.drv_step;
    exp_coil = drv.drv_SM ? tbl[m_phase] : 4'b0000;

    @(posedge clk);
    #1;
    if (step_done === 1'b1) done_cnt++;
    n_checks++;
    if (step_done !== acc) $display("FAIL step_done: got %b expected %b", step_done, acc);
    else n_pass++;
    n_checks++;
    if (busy !== (m_cnt != 0)) $display("FAIL busy: got %b expected %b", busy, (m_cnt != 0));
    else n_pass++;
    n_checks++;
    if (step_err !== m_err) $display("FAIL step_err: got %b expected %b", step_err, m_err);
    else n_pass++;
    n_checks++;
    if (coil !== exp_coil) $display("FAIL coil: got %b expected %b", coil, exp_coil);
    else n_pass++;
    if (step_done === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: step_done with no expected step queued");
      end else begin
        e = exp_q.pop_front();
        if (coil !== e.coil || position !== e.pos)
          $display("FAIL scoreboard: got coil %b pos %h expected coil %b pos %h",
                   coil, position, e.coil, e.pos);
        else n_pass++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    drv.drv_SM   = 1'b1;
    drv.drv_step = 1'b0;
    drv.drv_dir  = 1'b1;
    pos_clr      = 1'b0;
    #3 rst = 1'b0;
    m_phase = '0; m_pos = '0; m_cnt = 0; m_step = 1'b0; m_err = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({coil, position, step_done, step_err, busy} !== '0)
        $display("FAIL reset_state: got coil %b pos %h done %b err %b busy %b expected all 0",
                 coil, position, step_done, step_err, busy);
      else n_pass++;
      @(posedge clk);
    end
    #1 rst = 1'b1;
    tick();
    n_checks++;
    if (coil !== 4'b1100) $display("FAIL reset_release_coil: got %b expected 1100", coil);
    else n_pass++;
  endtask

  task automatic test_forward();
    logic [3:0] seq [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
    int d0;
    d0 = done_cnt;
    drv.drv_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv.drv_step = 1'b1;
      tick();
      n_checks++;
      if (coil !== seq[i]) $display("FAIL fwd_coil_%0d: got %b expected %b", i, coil, seq[i]);
      else n_pass++;
      drv.drv_step = 1'b0;
      idle(4);
    end
    n_checks++;
    if (position !== 16'd4) $display("FAIL fwd_position: got %h expected 0004", position);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 4) $display("FAIL fwd_done_count: got %0d expected 4", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_reverse();
    test_reset();
    drv.drv_dir  = 1'b0;
    drv.drv_step = 1'b1;
    tick();
    n_checks++;
    if (coil !== 4'b1001 || position !== 16'hFFFF)
      $display("FAIL reverse: got coil %b pos %h expected coil 1001 pos ffff", coil, position);
    else n_pass++;
    drv.drv_step = 1'b0;
    idle(4);
  endtask

  task automatic test_interval_reject();
    test_reset();
    drv.drv_dir  = 1'b1;
    drv.drv_step = 1'b1;
    tick();
    drv.drv_step = 1'b0;
    tick();
    drv.drv_step = 1'b1;
    tick();
    n_checks++;
    if (position !== 16'd1 || step_err !== 1'b1)
      $display("FAIL reject: got pos %h err %b expected pos 0001 err 1", position, step_err);
    else n_pass++;
    drv.drv_step = 1'b0;
    idle(3);
    pos_clr = 1'b1;
    tick();
    pos_clr = 1'b0;
    n_checks++;
    if (position !== 16'd0 || step_err !== 1'b0)
      $display("FAIL pos_clr: got pos %h err %b expected pos 0000 err 0", position, step_err);
    else n_pass++;
  endtask

  task automatic test_disable();
    drv.drv_SM = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drv.drv_step = 1'b1;
      tick();
      drv.drv_step = 1'b0;
      tick();
    end
    n_checks++;
    if (coil !== 4'b0000 || position !== 16'd0 || step_err !== 1'b0)
      $display("FAIL disabled: got coil %b pos %h err %b expected coil 0000 pos 0000 err 0",
               coil, position, step_err);
    else n_pass++;
    drv.drv_SM = 1'b1;
    tick();
    n_checks++;
    if (coil !== 4'b0110) $display("FAIL reenable_coil: got %b expected 0110", coil);
    else n_pass++;
  endtask

  task automatic test_wrap_and_clr();
    idle(4);
    force dut.pos_q = 16'h7FFF;
    @(negedge clk);
    release dut.pos_q;
    m_pos = 16'h7FFF;
    n_checks++;
    if (position !== 16'h7FFF) $display("FAIL preload: got %h expected 7fff", position);
    else n_pass++;
    drv.drv_dir  = 1'b1;
    drv.drv_step = 1'b1;
    tick();
    n_checks++;
    if (position !== 16'h8000 || coil !== 4'b0011)
      $display("FAIL wrap: got pos %h coil %b expected pos 8000 coil 0011", position, coil);
    else n_pass++;
    drv.drv_step = 1'b0;
    idle(4);
    drv.drv_step = 1'b1;
    pos_clr      = 1'b1;
    tick();
    n_checks++;
    if (position !== 16'd0 || coil !== 4'b1001 || step_done !== 1'b1)
      $display("FAIL step_with_clr: got pos %h coil %b done %b expected pos 0000 coil 1001 done 1",
               position, coil, step_done);
    else n_pass++;
    drv.drv_step = 1'b0;
    pos_clr      = 1'b0;
    idle(4);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_forward();
    test_reverse();
    test_interval_reject();
    test_disable();
    test_wrap_and_clr();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d steps never seen", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
